// File: rtl/health_pkg.sv
// Shared types and saturating arithmetic for the health tracker.
// Contents: hb_state_t channel FSM encoding; sat_sub / sat_add helpers
// evaluated on a widened word so no WIDTH (<= 32) value can wrap.
package health_pkg;

  // Per-channel contact-detection states.
  typedef enum logic [1:0] {
    WAITING = 2'd0,
    HIT     = 2'd1,
    BLOCK   = 2'd2,
    IDLE    = 2'd3
  } hb_state_t;

  // Arithmetic word: one bit wider than the largest supported WIDTH (32),
  // so both the sum and the difference of two WIDTH-bit operands fit.
  localparam int unsigned ARITH_W = 33;
  typedef logic [ARITH_W-1:0] arith_t;

  // Damage: clamps at zero instead of wrapping.
  function automatic arith_t sat_sub(input arith_t value, input arith_t dmg);
    return (value > dmg) ? (value - dmg) : '0;
  endfunction

  // Heal: clamps at the configured ceiling.
  function automatic arith_t sat_add(input arith_t value, input arith_t amt,
                                     input arith_t limit);
    arith_t sum;
    sum = value + amt;
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/health_channel.sv
// One player's health channel: contact FSM, health register, sticky KO flop.
// Ports: clk_i/rst_ni, round_start_i reload, hit_i/block_i/heal_i inputs,
//        health_o/ko_o registered outputs, ko_next_o next-state KO for the top-level OR.
module health_channel
  import health_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_HEALTH = 250,
  parameter int unsigned HIT_DMG    = 10,
  parameter int unsigned BLOCK_DMG  = 4,
  parameter int unsigned HEAL_AMT   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             round_start_i,
  input  logic             hit_i,
  input  logic             block_i,
  input  logic             heal_i,
  output logic [WIDTH-1:0] health_o,
  output logic             ko_o,
  output logic             ko_next_o
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(MAX_HEALTH);

  hb_state_t        state_q, state_d;
  logic [WIDTH-1:0] health_q, health_d;
  logic             ko_q, ko_d;

  logic   dmg_apply;
  arith_t dmg_amt;
  arith_t dmg_res;
  arith_t heal_res;

  always_comb begin
    dmg_amt = (state_q == HIT) ? arith_t'(HIT_DMG) : arith_t'(BLOCK_DMG);
    dmg_res = sat_sub(arith_t'(health_q), dmg_amt);
    heal_res = sat_add(arith_t'(health_q), arith_t'(HEAL_AMT), arith_t'(MAX_HEALTH));
  end

  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    ko_d      = ko_q;
    dmg_apply = 1'b0;

    if (ko_q) begin
      // A knocked-out player is frozen until the next round.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        WAITING: begin
          if (hit_i) begin
            state_d = HIT;
          end else if (block_i) begin
            state_d = BLOCK;
          end
        end
        HIT, BLOCK: begin
          state_d   = IDLE;
          dmg_apply = 1'b1;
          health_d  = dmg_res[WIDTH-1:0];
        end
        IDLE: begin
          // Re-arm only once the contact has ended.
          if (!hit_i && !block_i) begin
            state_d = WAITING;
          end
        end
        default: state_d = WAITING;
      endcase

      // Damage wins: a heal landing on the damage edge is dropped.
      if (heal_i && !dmg_apply) begin
        health_d = heal_res[WIDTH-1:0];
      end

      if (health_d == '0) begin
        ko_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || round_start_i) begin
      state_q  <= WAITING;
      health_q <= FULL;
      ko_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      ko_q     <= ko_d;
    end
  end

  assign health_o  = health_q;
  assign ko_o      = ko_q;
  assign ko_next_o = ko_d;

endmodule

// File: rtl/health_tracker.sv
// Multi-player health tracker: one health_channel per player plus a registered any_ko.
// Ports: Clk, Reset_n (sync, active-low), round_start reload, hit/block/heal per player,
//        health (flattened, player i at [i*WIDTH +: WIDTH]), ko per player, any_ko.
module health_tracker
  import health_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_HEALTH  = 250,
  parameter int unsigned HIT_DMG     = 10,
  parameter int unsigned BLOCK_DMG   = 4,
  parameter int unsigned HEAL_AMT    = 5
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         round_start,
  input  logic [NUM_PLAYERS-1:0]       hit,
  input  logic [NUM_PLAYERS-1:0]       block,
  input  logic [NUM_PLAYERS-1:0]       heal,
  output logic [NUM_PLAYERS*WIDTH-1:0] health,
  output logic [NUM_PLAYERS-1:0]       ko,
  output logic                         any_ko
);

  logic [NUM_PLAYERS-1:0] ko_next;
  logic                   any_ko_q, any_ko_d;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
    health_channel #(
      .WIDTH      (WIDTH),
      .MAX_HEALTH (MAX_HEALTH),
      .HIT_DMG    (HIT_DMG),
      .BLOCK_DMG  (BLOCK_DMG),
      .HEAL_AMT   (HEAL_AMT)
    ) u_chan (
      .clk_i         (Clk),
      .rst_ni        (Reset_n),
      .round_start_i (round_start),
      .hit_i         (hit[i]),
      .block_i       (block[i]),
      .heal_i        (heal[i]),
      .health_o      (health[i*WIDTH +: WIDTH]),
      .ko_o          (ko[i]),
      .ko_next_o     (ko_next[i])
    );
  end

  // OR the next-state KO bits so any_ko is a flop aligned with ko.
  always_comb begin
    any_ko_d = |ko_next;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n || round_start) begin
      any_ko_q <= 1'b0;
    end else begin
      any_ko_q <= any_ko_d;
    end
  end

  assign any_ko = any_ko_q;

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;

  localparam int NP   = 2;
  localparam int W    = 8;
  localparam int MAXH = 250;
  localparam int HD   = 10;
  localparam int BD   = 4;
  localparam int HA   = 5;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            round_start;
  logic [NP-1:0]   hit, block, heal;
  logic [NP*W-1:0] health;
  logic [NP-1:0]   ko;
  logic            any_ko;

  int checks = 0;
  int errors = 0;

  // Reference model: contact seen once per press, damage one edge later.
  int m_health [NP];
  int m_pend   [NP];   // damage queued for the next edge (0 = none)
  bit m_armed  [NP];   // ready to accept a new contact
  bit m_ko     [NP];

  health_tracker #(
    .NUM_PLAYERS (NP), .WIDTH (W), .MAX_HEALTH (MAXH),
    .HIT_DMG (HD), .BLOCK_DMG (BD), .HEAL_AMT (HA)
  ) dut (
    .Clk (Clk), .Reset_n (Reset_n), .round_start (round_start),
    .hit (hit), .block (block), .heal (heal),
    .health (health), .ko (ko), .any_ko (any_ko)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < NP; p++) begin
      bit applied;
      applied = 1'b0;
      if (!Reset_n || round_start) begin
        m_health[p] = MAXH; m_pend[p] = 0; m_armed[p] = 1'b1; m_ko[p] = 1'b0;
      end else if (m_ko[p]) begin
        m_pend[p] = 0; m_armed[p] = 1'b0;
      end else begin
        if (m_pend[p] != 0) begin
          applied     = 1'b1;
          m_health[p] = (m_health[p] > m_pend[p]) ? m_health[p] - m_pend[p] : 0;
          m_pend[p]   = 0;
          m_armed[p]  = 1'b0;
        end else if (m_armed[p]) begin
          if (hit[p])        m_pend[p] = HD;
          else if (block[p]) m_pend[p] = BD;
          if (hit[p] || block[p]) m_armed[p] = 1'b0;
        end else if (!hit[p] && !block[p]) begin
          m_armed[p] = 1'b1;
        end
        if (heal[p] && !applied)
          m_health[p] = (m_health[p] + HA > MAXH) ? MAXH : m_health[p] + HA;
        if (m_health[p] == 0) m_ko[p] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit any;
    any = 1'b0;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("health[%0d]", p), 32'(health[p*W +: W]), 32'(m_health[p]));
      check($sformatf("ko[%0d]", p), 32'(ko[p]), 32'(m_ko[p]));
      any |= m_ko[p];
    end
    check("any_ko", 32'(any_ko), 32'(any));
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic int hp(input int p);
    return int'(health[p*W +: W]);
  endfunction

  initial begin
    for (int p = 0; p < NP; p++) begin
      m_health[p] = MAXH; m_pend[p] = 0; m_armed[p] = 1'b1; m_ko[p] = 1'b0;
    end
    Reset_n = 1'b0; round_start = 1'b0; hit = '0; block = '0; heal = '0;

    // Reset held two cycles.
    step(); step();
    check("rst_h0", hp(0), MAXH);
    check("rst_h1", hp(1), MAXH);
    check("rst_ko", 32'(ko), 0);
    check("rst_any", 32'(any_ko), 0);
    Reset_n = 1'b1;

    // Held hit on player 0: exactly one -10, two edges after assertion.
    hit[0] = 1'b1;
    step(); check("hold_e1", hp(0), MAXH);
    step(); check("hold_e2", hp(0), 240);
    for (int k = 0; k < 18; k++) step();
    check("hold_end", hp(0), 240);
    check("hold_p1", hp(1), MAXH);
    hit[0] = 1'b0; step();

    // Hit and block together on player 1: hit wins.
    hit[1] = 1'b1; block[1] = 1'b1;
    step(); step(); step();
    check("hitblk", hp(1), 240);
    hit[1] = 1'b0; block[1] = 1'b0; step();
    block[1] = 1'b1; step(); step();
    check("blk_only", hp(1), 236);
    block[1] = 1'b0; step();

    // Player 0 down to 10 with single-cycle hit pulses.
    for (int k = 0; k < 23; k++) begin
      hit[0] = 1'b1; step(); hit[0] = 1'b0; step(); step();
    end
    check("to10", hp(0), 10);
    for (int k = 0; k < 3; k++) begin
      block[0] = 1'b1; step(); block[0] = 1'b0; step(); step();
    end
    check("ko_h0", hp(0), 0);
    check("ko_bit", 32'(ko[0]), 1);
    check("ko_any", 32'(any_ko), 1);
    hit[0] = 1'b1; step(); hit[0] = 1'b0; step(); step();
    heal[0] = 1'b1; step(); heal[0] = 1'b0; step();
    check("ko_frozen", hp(0), 0);

    // round_start after KO, then a hit aborted in flight.
    round_start = 1'b1; step(); round_start = 1'b0;
    check("rs_h0", hp(0), MAXH);
    check("rs_h1", hp(1), MAXH);
    check("rs_ko", 32'(ko), 0);
    hit[1] = 1'b1; step(); hit[1] = 1'b0;
    round_start = 1'b1; step(); round_start = 1'b0;
    step(); step();
    check("rs_abort", hp(1), MAXH);

    // Heal saturation: 250 -12 +10 = 248, then one heal clamps to 250.
    for (int k = 0; k < 3; k++) begin
      block[1] = 1'b1; step(); block[1] = 1'b0; step(); step();
    end
    heal[1] = 1'b1; step(); step(); heal[1] = 1'b0;
    check("heal_248", hp(1), 248);
    heal[1] = 1'b1; step(); heal[1] = 1'b0;
    check("heal_sat", hp(1), MAXH);

    // Heal on the damage edge is dropped.
    hit[1] = 1'b1; step(); hit[1] = 1'b0;
    heal[1] = 1'b1; step(); heal[1] = 1'b0; step();
    check("heal_vs_dmg", hp(1), 240);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      Reset_n     = ($urandom_range(0, 199) != 0);
      round_start = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        hit[p]   = ($urandom_range(0, 99) < 20);
        block[p] = ($urandom_range(0, 99) < 20);
        heal[p]  = ($urandom_range(0, 99) < 15);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/health_tracker.md
# health_tracker

Parametrised, multi-player health tracker for the fighting-game datapath. It converts level-held hit/block inputs from the collision logic into exactly one damage event per contact. Damage saturates at zero, and healing saturates at a configurable maximum. It raises a sticky KO flag per player and supports a round-restart reload. Outputs feed the health-bar sprite renderer and the game-flow controller.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of independent health channels
- WIDTH, 8, bits per health value
- MAX_HEALTH, 250, reset/reload value; must be < 2^WIDTH and > 0
- HIT_DMG, 10, damage per unblocked hit
- BLOCK_DMG, 4, chip damage per blocked hit
- HEAL_AMT, 5, health added per heal pulse

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  one clock; reset is synchronous and active-low
- round_start  in  1  single-cycle pulse; reloads all channels
- hit  in  NUM_PLAYERS  level; player i is being struck
- block  in  NUM_PLAYERS  level; player i is blocking a strike
- heal  in  NUM_PLAYERS  single-cycle pulse; heal player i
- health  out  NUM_PLAYERS*WIDTH  flattened; player i occupies bits [i*WIDTH +: WIDTH]
- ko  out  NUM_PLAYERS  sticky; player i health reached 0
- any_ko  out  1  OR of ko

## Operation
- Reset (Reset_n=0 at a rising edge) sets every health to MAX_HEALTH, sets every ko to 0 and any_ko to 0, and puts every FSM in WAITING.
- Each channel has an independent FSM with states WAITING, HIT, BLOCK, IDLE.
  - WAITING → HIT if hit[i]; else → BLOCK if block[i]. Hit has priority when both are high.
  - HIT → IDLE unconditionally. The channel applies HIT_DMG on this transition.
  - BLOCK → IDLE unconditionally. The channel applies BLOCK_DMG on this transition.
  - IDLE → WAITING only when hit[i]=0 and block[i]=0. A held input therefore never re-triggers damage.
- Damage arithmetic: health_next = (health > dmg) ? health − dmg : 0. Compute at WIDTH+1 bits; no wrap-around is permitted.
- Heal arithmetic: health_next = min(health + HEAL_AMT, MAX_HEALTH), computed at WIDTH+1 bits.
- Heal is ignored in the cycle in which damage is applied. Damage wins and the heal pulse is dropped.
- KO behaviour:
  - ko[i] is set in the cycle health[i] becomes 0.
  - While ko[i]=1, hit, block and heal for that channel are ignored. The FSM is forced to IDLE and stays there.
  - ko[i] clears only on reset or round_start.
- round_start has the same effect as reset on all channels. Reset takes precedence if both are asserted.

## Timing
- hit/block sampled high at edge k in WAITING → state HIT/BLOCK after edge k. Health is decremented at edge k+1. Total latency is 2 edges from the first sampled assertion.
- ko[i] and any_ko are registered. They update at the same edge as the health value that reaches 0.
- heal[i] sampled at edge k updates health at edge k (1-edge latency), provided no damage is applied at k.
- Input pulse rules:
  - A hit/block pulse lasting one cycle is caught if the FSM is in WAITING.
  - A pulse arriving in HIT, BLOCK or IDLE is lost.
- round_start takes effect at the same edge and aborts any in-flight HIT/BLOCK; no damage is applied.
- All outputs are driven directly from flops. There are no combinational input-to-output paths.

## Structure
- Shared package health_pkg holds:
  - the typedef enum logic [1:0] hb_state_t {WAITING, HIT, BLOCK, IDLE}
  - the damage/heal saturation functions, parametrised by width
- Sub-module health_channel holds one FSM, one health register and one ko flop, with the same parameters minus NUM_PLAYERS.
- The top level is a generate loop over NUM_PLAYERS plus the any_ko reduction.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles → health = 250 on both players, ko=0, any_ko=0.
- Held hit: hit[0] high for 20 cycles → health[0] goes 250→240 exactly once, 2 edges after the assertion. health[1] stays at 250.
- Hit and block together on player 1: block[1] and hit[1] high simultaneously → health[1] = 240, not 246. Then release both, assert block[1] → 236.
- Saturation and KO: 24 hits on player 0 take health to 10. Then block → 6, block → 2, block → 0 with ko[0]=1 and any_ko=1. A further hit or heal leaves health at 0.
- Heal: from 248, one heal pulse → 250, not 253. Heal asserted in the same cycle a hit is applied → only the −10 takes effect.
- round_start after KO: health = 250 on both players, ko=0. A hit in flight at round_start applies no damage.
